alu_pool_arbiter: RTL
=====================

ALU_POOL_ARBITER -- requirements
Module: alu_pool_arbiter

Interface
REQ-001 Parameters SHALL be: NUM_SIC, default 4, number of requesting SICs; NUM_ALUS, default 2, number of ALU units in the pool; ID_WIDTH, default 4, issue-id width.
REQ-002 The clock SHALL be clk  input  1  rising-edge clock.
REQ-003 The reset SHALL be rst_n  input  1  asynchronous, active-low reset.
REQ-004 oldest_issue_id  input  ID_WIDTH  SHALL be the oldest in-flight issue id from the issue controller, used as the age base.
REQ-005 sic_req[NUM_SIC]  input  1  SHALL request an ALU lock.
REQ-006 sic_issue_id[NUM_SIC]  input  ID_WIDTH  SHALL carry the requester's issue id.
REQ-007 sic_release[NUM_SIC]  input  1  SHALL be a single-cycle lock-release pulse.
REQ-008 sic_op_a, sic_op_b[NUM_SIC]  input  32 each  SHALL carry the operands.
REQ-009 sic_opcode[NUM_SIC]  input  6  SHALL carry the ALU function code.
REQ-010 sic_grant[NUM_SIC]  output  1  SHALL indicate that the SIC currently owns an ALU.
REQ-011 sic_res[NUM_SIC]  output  32, sic_zero and sic_over[NUM_SIC]  output  1 each  SHALL carry the owned ALU's result and flags.
REQ-012 alu_a, alu_b[NUM_ALUS]  output  32 each, and alu_op[NUM_ALUS]  output  6,  SHALL drive the ALU unit inputs.
REQ-013 alu_res[NUM_ALUS]  input  32, and alu_zero, alu_over[NUM_ALUS]  input  1 each,  SHALL be the ALU unit outputs.
REQ-014 busy_count  output  clog2(NUM_ALUS+1)  SHALL report the number of owned slots.
REQ-015 err_spurious_release  output  1  SHALL be a sticky error flag.

Function
REQ-016 Each ALU slot SHALL hold the registered state {owned, owner_idx}; a SIC SHALL own at most one slot.
REQ-017 sic_grant[i] SHALL be a registered output that is 1 exactly while SIC i owns a slot; grant latency from a first sic_req to sic_grant is 1 cycle when a slot is free.
REQ-018 Ownership SHALL persist until sic_release[i] is sampled, independent of sic_req (the SIC drops req one cycle before its release pulse).
REQ-019 A release SHALL free the slot at the sampling edge; the freed slot becomes allocatable at the following edge (no same-edge reuse).
REQ-020 Allocation SHALL happen at each edge: pending requesters (req=1, not owning, not releasing) are ranked by age = (sic_issue_id - oldest_issue_id) mod 2^ID_WIDTH, smallest first; equal age SHALL break to the lower SIC index.
REQ-021 Free slots SHALL be assigned in ascending slot index to ranked requesters; up to min(free slots, pending requesters) grants SHALL be issued per cycle.
REQ-022 Age comparison SHALL handle wrap-around (e.g. base 14: id 15 is older than id 1).
REQ-023 alu_a/alu_b/alu_op[k] SHALL combinationally select the owner's sic_op_a/sic_op_b/sic_opcode; a free slot SHALL drive zeros.
REQ-024 sic_res/zero/over[i] SHALL combinationally return the owned slot's outputs; a non-owner SHALL see zeros.
REQ-025 A release from a non-owner SHALL be ignored and SHALL set err_spurious_release until reset.
REQ-026 A simultaneous release by SIC i and request by SIC j SHALL grant j the next free slot only after the freeing edge (REQ-019).
REQ-027 busy_count SHALL equal the number of owned slots after each edge.
REQ-028 With all slots owned, requests SHALL stall with grant=0 and no state change.

Reset
REQ-029 On rst_n=0 all slots SHALL become free immediately, and sic_grant=0, busy_count=0, err_spurious_release=0; all data outputs SHALL be 0.
REQ-030 Reset asserted mid-ownership SHALL drop all grants with no release pulses required afterwards.

Structure
REQ-031 NUM_ALUS, ID_WIDTH and the slot-state typedef {owned, owner_idx} SHALL reside in the shared package alongside sic_packet_t.
REQ-032 The ranking logic SHALL be a sub-module alu_age_picker that produces the oldest-first pending order from ids, base and valid bits.

Verification
REQ-033 Reset, then SIC0 req with id 3, base 0 -> sic_grant[0]=1 one cycle later, busy_count=1; alu_a[0] equals sic_op_a[0].
REQ-034 SIC0..3 req in the same cycle with ids 5,2,7,3, base 2 -> SIC1 gets slot0 and SIC3 gets slot1; SIC0 and SIC2 stay at grant=0.
REQ-035 Wrap case: base 14, ids 1 and 15 both pending with one free slot -> the SIC with id 15 is granted.
REQ-036 SIC1 releases slot0 while SIC2 requests with all slots full -> sic_grant[2] rises two edges after the release cycle, and busy_count dips to 1 for one cycle.
REQ-037 Release pulse from non-owner SIC3 -> no state change and err_spurious_release=1, held until rst_n.
REQ-038 Assert rst_n=0 while 2 slots are owned -> all grants drop asynchronously, and post-reset requests are granted normally.

Source files
------------

// File: rtl/alu_pool_arbiter_pkg.sv
// alu_pool_arbiter_pkg
// Shared definitions for the ALU pool arbiter slice.
//   NUM_SIC / NUM_ALUS / ID_WIDTH : default pool geometry
//   DATA_W / OPCODE_W             : operand and function-code widths
//   SIC_IDX_W                     : width of a slot's owner index (up to 16 SICs)
//   slot_state_t                  : per-ALU-slot ownership record
//   sic_packet_t                  : operand bundle a SIC presents to its ALU
package alu_pool_arbiter_pkg;

    localparam int NUM_SIC   = 4;
    localparam int NUM_ALUS  = 2;
    localparam int ID_WIDTH  = 4;
    localparam int DATA_W    = 32;
    localparam int OPCODE_W  = 6;
    localparam int SIC_IDX_W = 4;

    typedef struct packed {
        logic                 owned;
        logic [SIC_IDX_W-1:0] owner_idx;
    } slot_state_t;

    typedef struct packed {
        logic [DATA_W-1:0]   op_a;
        logic [DATA_W-1:0]   op_b;
        logic [OPCODE_W-1:0] opcode;
    } sic_packet_t;

endpackage

// File: rtl/alu_pool_arbiter_age_picker.sv
// alu_age_picker
// Ranks valid requesters oldest-first. Age is the issue id measured from the
// in-flight base modulo 2^ID_WIDTH, so the ranking is wrap-around safe.
// Equal ages break toward the lower requester index.
//   ids[NUM_SIC]  : requester issue ids
//   base          : oldest in-flight issue id (age origin)
//   valid         : requesters taking part in the ranking
//   rank[NUM_SIC] : position of each valid requester in the order (0 = oldest);
//                   don't-care for requesters that are not valid
module alu_age_picker #(
    parameter int NUM_SIC  = 4,
    parameter int ID_WIDTH = 4,
    parameter int RANK_W   = 3
) (
    input  logic [ID_WIDTH-1:0] ids  [NUM_SIC],
    input  logic [ID_WIDTH-1:0] base,
    input  logic [NUM_SIC-1:0]  valid,
    output logic [RANK_W-1:0]   rank [NUM_SIC]
);

    logic [ID_WIDTH-1:0] age [NUM_SIC];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SIC; gi++) begin : g_rank
            logic [RANK_W-1:0] rank_loc;

            // Unsigned subtraction wraps, giving the modular distance from base.
            assign age[gi] = ids[gi] - base;

            // Rank = number of valid requesters that beat this one.
            always_comb begin
                int older;
                older = 0;
                for (int j = 0; j < NUM_SIC; j++) begin
                    if (valid[j] && ((age[j] < age[gi]) || ((age[j] == age[gi]) && (j < gi)))) begin
                        older++;
                    end
                end
                rank_loc = RANK_W'(older);
            end

            assign rank[gi] = rank_loc;
        end
    endgenerate

endmodule

// File: rtl/alu_pool_arbiter.sv
// alu_pool_arbiter
// Shares a pool of NUM_ALUS ALUs among NUM_SIC requesters. Each slot holds
// {owned, owner_idx}; a requester owns at most one slot until it pulses
// sic_release. Free slots go, in ascending slot order, to pending requesters
// ranked oldest-first by issue id. A slot freed at an edge is only
// re-allocatable at the next edge.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   oldest_issue_id                   : age origin
//   sic_req / sic_issue_id / sic_release / sic_op_a / sic_op_b / sic_opcode
//                                     : per-SIC request side
//   sic_grant / sic_res / sic_zero / sic_over : per-SIC ownership and results
//   alu_a / alu_b / alu_op            : per-ALU operand drive (zero when free)
//   alu_res / alu_zero / alu_over     : per-ALU results
//   busy_count                        : number of owned slots
//   err_spurious_release              : sticky, release seen from a non-owner
module alu_pool_arbiter
    import alu_pool_arbiter_pkg::*;
#(
    parameter int NUM_SIC  = alu_pool_arbiter_pkg::NUM_SIC,
    parameter int NUM_ALUS = alu_pool_arbiter_pkg::NUM_ALUS,
    parameter int ID_WIDTH = alu_pool_arbiter_pkg::ID_WIDTH
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [ID_WIDTH-1:0]             oldest_issue_id,
    input  logic [NUM_SIC-1:0]              sic_req,
    input  logic [ID_WIDTH-1:0]             sic_issue_id [NUM_SIC],
    input  logic [NUM_SIC-1:0]              sic_release,
    input  logic [DATA_W-1:0]               sic_op_a     [NUM_SIC],
    input  logic [DATA_W-1:0]               sic_op_b     [NUM_SIC],
    input  logic [OPCODE_W-1:0]             sic_opcode   [NUM_SIC],
    output logic [NUM_SIC-1:0]              sic_grant,
    output logic [DATA_W-1:0]               sic_res      [NUM_SIC],
    output logic [NUM_SIC-1:0]              sic_zero,
    output logic [NUM_SIC-1:0]              sic_over,
    output logic [DATA_W-1:0]               alu_a        [NUM_ALUS],
    output logic [DATA_W-1:0]               alu_b        [NUM_ALUS],
    output logic [OPCODE_W-1:0]             alu_op       [NUM_ALUS],
    input  logic [DATA_W-1:0]               alu_res      [NUM_ALUS],
    input  logic [NUM_ALUS-1:0]             alu_zero,
    input  logic [NUM_ALUS-1:0]             alu_over,
    output logic [$clog2(NUM_ALUS+1)-1:0]   busy_count,
    output logic                            err_spurious_release
);

    localparam int RANK_W = $clog2(NUM_SIC + 1);
    localparam int BUSY_W = $clog2(NUM_ALUS + 1);

    slot_state_t        slot_reg  [NUM_ALUS];
    slot_state_t        slot_next [NUM_ALUS];
    logic               err_reg, err_next;
    sic_packet_t        sic_pkt   [NUM_SIC];
    logic [NUM_SIC-1:0] owns;
    logic [NUM_SIC-1:0] pending;
    logic [RANK_W-1:0]  rank      [NUM_SIC];

    // Which SICs currently own a slot, decoded from the slot registers.
    always_comb begin
        owns = '0;
        for (int k = 0; k < NUM_ALUS; k++) begin
            for (int i = 0; i < NUM_SIC; i++) begin
                if (slot_reg[k].owned && (slot_reg[k].owner_idx == SIC_IDX_W'(i))) begin
                    owns[i] = 1'b1;
                end
            end
        end
    end

    // A releasing SIC never competes at the same edge, owner or not.
    assign pending   = sic_req & ~owns & ~sic_release;
    assign sic_grant = owns;

    alu_age_picker #(
        .NUM_SIC  (NUM_SIC),
        .ID_WIDTH (ID_WIDTH),
        .RANK_W   (RANK_W)
    ) u_age_picker (
        .ids   (sic_issue_id),
        .base  (oldest_issue_id),
        .valid (pending),
        .rank  (rank)
    );

    // Allocation only looks at slots free before this edge, so a slot being
    // released now cannot be handed out until the next edge. The n-th free
    // slot (ascending) goes to the requester of rank n.
    always_comb begin
        int free_cnt;
        free_cnt  = 0;
        slot_next = slot_reg;
        err_next  = err_reg | (|(sic_release & ~owns));
        for (int k = 0; k < NUM_ALUS; k++) begin
            if (!slot_reg[k].owned) begin
                for (int i = 0; i < NUM_SIC; i++) begin
                    if (pending[i] && (int'(rank[i]) == free_cnt)) begin
                        slot_next[k].owned     = 1'b1;
                        slot_next[k].owner_idx = SIC_IDX_W'(i);
                    end
                end
                free_cnt++;
            end else begin
                for (int i = 0; i < NUM_SIC; i++) begin
                    if (sic_release[i] && (slot_reg[k].owner_idx == SIC_IDX_W'(i))) begin
                        slot_next[k] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_ALUS; k++) begin
                slot_reg[k] <= '0;
            end
            err_reg <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_ALUS; k++) begin
                slot_reg[k] <= slot_next[k];
            end
            err_reg <= err_next;
        end
    end

    assign err_spurious_release = err_reg;

    always_comb begin
        busy_count = '0;
        for (int k = 0; k < NUM_ALUS; k++) begin
            if (slot_reg[k].owned) begin
                busy_count = busy_count + BUSY_W'(1);
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SIC; gi++) begin : g_pkt
            assign sic_pkt[gi] = '{op_a: sic_op_a[gi], op_b: sic_op_b[gi], opcode: sic_opcode[gi]};
        end

        // Operand steering: each slot forwards its owner's packet, zeros if free.
        for (gi = 0; gi < NUM_ALUS; gi++) begin : g_alu
            sic_packet_t sel_pkt;
            always_comb begin
                sel_pkt = '0;
                for (int i = 0; i < NUM_SIC; i++) begin
                    if (slot_reg[gi].owned && (slot_reg[gi].owner_idx == SIC_IDX_W'(i))) begin
                        sel_pkt = sic_pkt[i];
                    end
                end
            end
            assign alu_a[gi]  = sel_pkt.op_a;
            assign alu_b[gi]  = sel_pkt.op_b;
            assign alu_op[gi] = sel_pkt.opcode;
        end

        // Result return: each SIC sees its slot's outputs, zeros if it owns none.
        for (gi = 0; gi < NUM_SIC; gi++) begin : g_ret
            logic [DATA_W-1:0] res_sel;
            logic              zero_sel;
            logic              over_sel;
            always_comb begin
                res_sel  = '0;
                zero_sel = 1'b0;
                over_sel = 1'b0;
                for (int k = 0; k < NUM_ALUS; k++) begin
                    if (slot_reg[k].owned && (slot_reg[k].owner_idx == SIC_IDX_W'(gi))) begin
                        res_sel  = alu_res[k];
                        zero_sel = alu_zero[k];
                        over_sel = alu_over[k];
                    end
                end
            end
            assign sic_res[gi]  = res_sel;
            assign sic_zero[gi] = zero_sel;
            assign sic_over[gi] = over_sel;
        end
    endgenerate

endmodule
